// File: rtl/bfp16_accumulator.sv
// Streaming BFP16 reduction: sums one product term per cycle into a single BFP16
// result. Truncating arithmetic, denormals flushed to zero, and sticky inf/NaN flags.
module bfp16_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [15:0] QNAN = 16'h7FC0;

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nan_q, nan_d;
  logic             inf_q, inf_d;
  logic [15:0]      odata_q, odata_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;

  logic [15:0]      sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             term_special;

  function automatic logic [2:0] clz8(input logic [7:0] v);
    logic [2:0] n;
    n = 3'd7;
    for (int i = 0; i <= 7; i++) begin
      if (v[i]) n = 3'(7 - i);
    end
    return n;
  endfunction

  function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]       big, sml;
    logic [7:0]        d, m_b, m_s, m_al, m_n;
    logic [8:0]        s9;
    logic [2:0]        lz;
    logic signed [9:0] e_n;
    a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
    b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
    a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
    b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
    a_zero = (a[14:7] == 8'h00);
    b_zero = (b[14:7] == 8'h00);
    if (a_nan || b_nan) return QNAN;
    if (a_inf && b_inf) return (a[15] != b[15]) ? QNAN : a;
    if (a_inf) return a;
    if (b_inf) return b;
    // Both zero (denormals included) collapse to a canonical zero; -0 only from -0 + -0.
    if (a_zero && b_zero) return {a[15] & b[15], 15'd0};
    if (a_zero) return b;
    if (b_zero) return a;
    if (a[14:0] >= b[14:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d    = big[14:7] - sml[14:7];
    m_b  = {1'b1, big[6:0]};
    m_s  = {1'b1, sml[6:0]};
    m_al = (d >= 8'd8) ? 8'd0 : (m_s >> d[2:0]);
    if (a[15] == b[15]) begin
      s9 = {1'b0, m_b} + {1'b0, m_al};
      if (s9[8]) begin
        if (big[14:7] == 8'hFE) return {big[15], 8'hFF, 7'd0};
        return {big[15], big[14:7] + 8'd1, s9[7:1]};
      end
      return {big[15], big[14:7], s9[6:0]};
    end
    m_n = m_b - m_al;
    if (m_n == 8'd0) return 16'h0000;
    lz  = clz8(m_n);
    e_n = $signed({2'b00, big[14:7]}) - $signed({7'd0, lz});
    if (e_n <= 10'sd0) return {big[15], 15'd0};
    m_n = m_n << lz;
    return {big[15], e_n[7:0], m_n[6:0]};
  endfunction

  assign term_special = (in_data[14:7] == 8'hFF);
  assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Sticky flags short-circuit the adder: NaN absorbs everything, inf ignores finite terms.
  always_comb begin
    if (nan_q)                       sum = QNAN;
    else if (inf_q && !term_special) sum = acc_q;
    else                             sum = bf_add(acc_q, in_data);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    nan_d   = nan_q;
    inf_d   = inf_q;
    odata_d = odata_q;
    ocnt_d  = ocnt_q;
    case (state_q)
      IDLE, ACC: begin
        if (in_valid) begin
          acc_d   = sum;
          cnt_d   = cnt_inc;
          nan_d   = (sum[14:7] == 8'hFF) && (sum[6:0] != 7'd0);
          inf_d   = (sum[14:7] == 8'hFF) && (sum[6:0] == 7'd0);
          state_d = ACC;
          if (in_last) begin
            state_d = HOLD;
            odata_d = sum;
            ocnt_d  = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = 16'h0000;
          cnt_d   = '0;
          nan_d   = 1'b0;
          inf_d   = 1'b0;
          odata_d = 16'h0000;
          ocnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      acc_q   <= 16'h0000;
      cnt_q   <= '0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      odata_q <= 16'h0000;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      odata_q <= odata_d;
      ocnt_q  <= ocnt_d;
    end
  end

  assign in_ready  = !RST && (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_data  = odata_q;
  assign out_count = ocnt_q;

endmodule

// File: doc/bfp16_accumulator.md
Name: bfp16_accumulator

Overview:
- Streaming BFP16 reduction stage directly downstream of the BFP16 multiplier: sums a sequence of product terms into one BFP16 result, one term per cycle.
- Used per PE column to form dot products; a term stream is delimited by in_last.
- Format: 1 sign bit, 8 exponent bits (bias 127), 7 fraction bits.
- Rounding is truncation throughout.

Parameters:
- CNT_W, 16, width of the term counter.
- The counter saturates at 2^CNT_W-1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- in_data  input  16  BFP16 product term.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  term is the final term of the current reduction; qualified by in_valid.
- in_ready  output  1  block accepts a term this cycle.
- out_data  output  16  BFP16 reduction result.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts out_data.
- out_count  output  CNT_W  number of terms in the result, saturating.

Behaviour:
- Reset: asynchronous on RST high.
  - State=IDLE, accumulator=0x0000, count=0, special flags cleared.
  - out_valid=0, out_data=0x0000, out_count=0.
  - in_ready=1 once RST deasserts.
- States:
  - IDLE: accumulator 0, no terms accepted yet.
  - ACC: at least one term accepted, no last term yet.
  - HOLD: result presented on the output.
- in_ready=1 in IDLE and ACC, 0 in HOLD. A term is accepted when in_valid and in_ready are both high.
- Accept without in_last: acc <= acc + in_data and count++. IDLE->ACC, ACC stays ACC.
- Accept with in_last: acc and count update the same way, then go to HOLD.
  - On the next cycle out_valid=1, out_data=the updated sum, out_count=the updated count.
  - Latency from the last-term handshake to out_valid is 1 cycle.
- HOLD:
  - out_data and out_count stay stable while out_ready=0.
  - When out_ready=1: out_valid->0, acc->0x0000, count->0, flags cleared, state->IDLE.
  - in_ready returns to 1 on the following cycle; there is no same-cycle accept in HOLD.
- out_data and out_count are registered and change only on the last-term accept and the HOLD exit. They read 0 after the HOLD exit.
- Addition rules (combinational, one per cycle):
  - Operand decode: exp=0 means zero; the fraction is ignored, so denormals flush to zero.
  - exp=255 with fraction 0 is +/-inf. exp=255 with fraction nonzero is NaN.
  - Zero operand: the result is the other operand unchanged, except 0x8000+0x8000=0x8000.
  - Big/small ordering: the operand with the larger {exp,frac} magnitude is "big". Mantissa m={1,frac}, 8 bits.
  - Alignment: d = exp_big - exp_small. The small mantissa is shifted right by d with truncation; d>=8 contributes 0.
  - Same sign: 9-bit sum. On a carry, shift right by 1 and exp+1. exp reaching 255 gives inf with the sign of big.
  - Different sign: difference m_big - m_small_aligned. A result of 0 gives +0 (0x0000).
  - Otherwise normalise by left-shifting until bit7=1, with exp reduced by the shift count. An exp <=0 gives a signed zero (sign of big).
  - Result sign is the sign of big.
- Special flags are sticky until the HOLD exit:
  - Any NaN term, or +inf meeting -inf, sets nan. Result is 0x7FC0.
  - Any inf with nan clear sets inf with its sign. Result is 0x7F80 or 0xFF80, and later finite terms are ignored.
- Count: increments per accepted term and saturates at 2^CNT_W-1.
- in_last is ignored unless in_valid is high. in_valid is ignored in HOLD; the upstream stage holds its data.
- RST mid-reduction discards the partial sum and count immediately.

Test Plan:
- Two-term stream 0x3F80 then 0x4000 (last) -> one cycle later out_valid=1, out_data=0x4040, out_count=2.
- Stream 0x3F80, 0xBF80 (last) -> out_data=0x0000. Then stream 0x3F80, 0x3B00 (2^-9, last) -> out_data=0x3F80 (truncated).
- Overflow: 0x7F7F, 0x7F7F (last) -> out_data=0x7F80.
- Specials:
  - 0x7F80, 0xFF80, 0x3F80 (last) -> 0x7FC0.
  - 0x7FC1, 0x4000 (last) -> 0x7FC0.
  - Denormal 0x0001 + 0x3F80 (last) -> 0x3F80.
- Backpressure: single term 0x4040 with in_last, out_ready low for 3 cycles -> in_ready=0 and out_data=0x4040 stable, out_count=1. out_ready high -> out_valid=0 next cycle, in_ready=1 the cycle after.
- Reset mid-operation: accept 0x3F80, 0x4000 without last, pulse RST asynchronously between edges -> outputs zero immediately. Then 0x3F80 (last) -> out_data=0x3F80, out_count=1.
